// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter
//   Shares one single-port unified memory between the uDLX instruction-fetch
//   port and the data (load/store) port. Requests are arbitrated round-robin
//   in IDLE, registered onto a req/ack memory handshake, and completed with a
//   one-cycle valid pulse per port. A grant that sees no mem_ack for
//   TIMEOUT_CYCLES cycles is completed with read data 0 and flags timeout_err.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   instr_rd_en/instr_addr     fetch request (level) and address
//   instruction/instr_valid    fetched word (held) and completion pulse
//   data_rd_en/data_wr_en      load/store request (level); both high = store
//   data_addr/data_write       load/store address and store data
//   data_read/data_valid       load result (held) and completion pulse
//   core_stall                 core must freeze while a request is unserved
//   mem_req/mem_we/mem_addr/
//   mem_wdata                  registered memory request, stable until done
//   mem_rdata/mem_ack          memory read data and one-cycle completion
//   timeout_err                sticky abort flag, cleared only by rst

module dlx_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 20,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_rd_en,
  input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0]      instruction,
  output logic                       instr_valid,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       data_valid,
  output logic                       core_stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_ack,
  output logic                       timeout_err
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // The grant cycle that sees the timer at this value is the last one allowed,
  // so mem_req stays high for exactly TIMEOUT_CYCLES cycles without an ack.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;
  typedef enum logic {OWNER_INSTR, OWNER_DATA} owner_e;

  state_e                     state, state_next;
  owner_e                     last_grant, last_grant_next;
  logic [TIMER_WIDTH-1:0]     timer, timer_next;
  logic                       mem_req_next, mem_we_next;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0]      mem_wdata_next;
  logic [DATA_WIDTH-1:0]      instruction_next, data_read_next;
  logic                       instr_valid_next, data_valid_next, timeout_err_next;

  logic                       instr_elig, data_elig;
  logic                       pick_data, done, timed_out;
  logic [DATA_WIDTH-1:0]      completion_word;

  // A port whose valid pulse is high this cycle is still holding the request
  // it just had served, so it must not be granted again in the same cycle.
  assign instr_elig = instr_rd_en & ~instr_valid;
  assign data_elig  = (data_rd_en | data_wr_en) & ~data_valid;

  assign core_stall = (instr_rd_en & ~instr_valid) | ((data_rd_en | data_wr_en) & ~data_valid);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_next       = state;
    last_grant_next  = last_grant;
    timer_next       = timer;
    mem_req_next     = mem_req;
    mem_we_next      = mem_we;
    mem_addr_next    = mem_addr;
    mem_wdata_next   = mem_wdata;
    instruction_next = instruction;
    data_read_next   = data_read;
    instr_valid_next = 1'b0;
    data_valid_next  = 1'b0;
    timeout_err_next = timeout_err;
    pick_data        = 1'b0;
    done             = 1'b0;
    timed_out        = 1'b0;
    completion_word  = mem_rdata;

    case (state)
      IDLE: begin
        // Data wins when it is the only eligible port, or when both are
        // eligible and instruction fetch was served last.
        pick_data = data_elig & (~instr_elig | (last_grant == OWNER_INSTR));
        if (pick_data) begin
          state_next      = GRANT_D;
          last_grant_next = OWNER_DATA;
          timer_next      = '0;
          mem_req_next    = 1'b1;
          mem_we_next     = data_wr_en;
          mem_addr_next   = data_addr;
          mem_wdata_next  = data_write;
        end else if (instr_elig) begin
          state_next      = GRANT_I;
          last_grant_next = OWNER_INSTR;
          timer_next      = '0;
          mem_req_next    = 1'b1;
          mem_we_next     = 1'b0;
          mem_addr_next   = DATA_ADDR_WIDTH'(instr_addr);
          mem_wdata_next  = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        if (mem_ack) begin
          done = 1'b1;
        end else if (timer == TIMER_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end

        if (done) begin
          completion_word = timed_out ? '0 : mem_rdata;
          state_next      = IDLE;
          mem_req_next    = 1'b0;
          timer_next      = '0;
          if (timed_out) timeout_err_next = 1'b1;
          if (state == GRANT_I) begin
            instr_valid_next = 1'b1;
            instruction_next = completion_word;
          end else begin
            data_valid_next = 1'b1;
            if (!mem_we) data_read_next = completion_word;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= OWNER_INSTR;
      timer       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instruction <= '0;
      data_read   <= '0;
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge and all of them update together.
      state       <= state_next;
      last_grant  <= last_grant_next;
      timer       <= timer_next;
      mem_req     <= mem_req_next;
      mem_we      <= mem_we_next;
      mem_addr    <= mem_addr_next;
      mem_wdata   <= mem_wdata_next;
      instruction <= instruction_next;
      data_read   <= data_read_next;
      instr_valid <= instr_valid_next;
      data_valid  <= data_valid_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Self-checking bench for dlx_mem_arbiter: directed scenarios with literal
// expectations, then randomized core/memory traffic checked every cycle
// against a transaction-level model of the arbiter.

module tb_dlx_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_rd_en = 1'b0;
  logic [19:0] instr_addr = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        data_rd_en = 1'b0;
  logic        data_wr_en = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_write = '0;
  logic [31:0] data_read;
  logic        data_valid;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        timeout_err;

  dlx_mem_arbiter #(
    .DATA_WIDTH(32), .INST_ADDR_WIDTH(20), .DATA_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_addr(instr_addr),
    .instruction(instruction), .instr_valid(instr_valid),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en),
    .data_addr(data_addr), .data_write(data_write),
    .data_read(data_read), .data_valid(data_valid),
    .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  bit          random_mode = 1'b0;
  int          ack_delay   = 0;
  logic [31:0] rdata_value = '0;
  bit          in_txn      = 1'b0;
  int          wait_cnt    = 0;
  int          cur_delay   = 0;

  always begin
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = random_mode ? $urandom : rdata_value;
    if (rst || !mem_req) begin
      in_txn = 1'b0;
      // Stray acks while nothing is requested must be ignored.
      if (random_mode && !rst && ($urandom_range(0, 7) == 0)) mem_ack = 1'b1;
    end else begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        wait_cnt = 0;
        if (random_mode)
          cur_delay = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO, TO + 2))
                                                   : int'($urandom_range(0, TO - 1));
        else
          cur_delay = ack_delay;
      end
      if (wait_cnt == cur_delay) mem_ack = 1'b1;
      wait_cnt++;
    end
  end

  // ---------------- random core driver ----------------
  always begin
    @(posedge clk);
    #1;
    if (random_mode && !rst) begin
      if (instr_rd_en && instr_valid) begin
        if ($urandom_range(0, 1) == 0) instr_rd_en = 1'b0;
        else instr_addr = 20'($urandom);
      end else if (!instr_rd_en && ($urandom_range(0, 2) == 0)) begin
        instr_rd_en = 1'b1;
        instr_addr  = 20'($urandom);
      end
      if ((data_rd_en || data_wr_en) && data_valid && ($urandom_range(0, 1) == 0)) begin
        data_rd_en = 1'b0;
        data_wr_en = 1'b0;
      end else if (((data_rd_en || data_wr_en) && data_valid) ||
                   (!(data_rd_en || data_wr_en) && ($urandom_range(0, 2) == 0))) begin
        case ($urandom_range(0, 3))
          0, 1:    begin data_rd_en = 1'b1; data_wr_en = 1'b0; end
          2:       begin data_rd_en = 1'b0; data_wr_en = 1'b1; end
          default: begin data_rd_en = 1'b1; data_wr_en = 1'b1; end
        endcase
        data_addr  = $urandom;
        data_write = $urandom;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  // One outstanding memory transaction at most; a served port pulses valid
  // for one cycle and may not be re-granted during that pulse.
  typedef struct {
    bit          active;
    bit          is_data;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          age;
  } txn_t;

  txn_t        cur;
  bit          m_last_data = 1'b0;
  bit          m_ivalid = 1'b0, m_dvalid = 1'b0, m_terr = 1'b0;
  logic [31:0] m_instr = '0, m_dread = '0;
  bit          want_i, want_d, pick_d, fin, n_iv, n_dv;
  logic [31:0] rd_word;
  bit          stall_exp;

  initial cur = '{active: 1'b0, is_data: 1'b0, addr: '0, we: 1'b0, wdata: '0, age: 0};

  always @(negedge clk) begin
    stall_exp = (instr_rd_en && !m_ivalid) || ((data_rd_en || data_wr_en) && !m_dvalid);
    if (rst) begin
      cur.active  = 1'b0;
      m_last_data = 1'b0;
      m_ivalid    = 1'b0;
      m_dvalid    = 1'b0;
      m_terr      = 1'b0;
      m_instr     = '0;
      m_dread     = '0;
      check("rst_mem_req", mem_req, 0);
      check("rst_valids", {instr_valid, data_valid}, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_stall", core_stall, (instr_rd_en || data_rd_en || data_wr_en));
    end else begin
      check("mdl_mem_req", mem_req, cur.active);
      if (cur.active) begin
        check("mdl_mem_addr", mem_addr, cur.addr);
        check("mdl_mem_we", mem_we, cur.we);
        check("mdl_mem_wdata", mem_wdata, cur.wdata);
      end
      check("mdl_instr_valid", instr_valid, m_ivalid);
      check("mdl_data_valid", data_valid, m_dvalid);
      check("mdl_instruction", instruction, m_instr);
      check("mdl_data_read", data_read, m_dread);
      check("mdl_timeout_err", timeout_err, m_terr);
      check("mdl_core_stall", core_stall, stall_exp);

      n_iv = 1'b0;
      n_dv = 1'b0;
      if (cur.active) begin
        fin     = 1'b0;
        rd_word = mem_rdata;
        if (mem_ack) begin
          fin = 1'b1;
        end else begin
          cur.age++;
          if (cur.age == TO) begin
            fin     = 1'b1;
            rd_word = '0;
            m_terr  = 1'b1;
          end
        end
        if (fin) begin
          cur.active = 1'b0;
          if (cur.is_data) begin
            n_dv = 1'b1;
            if (!cur.we) m_dread = rd_word;
          end else begin
            n_iv    = 1'b1;
            m_instr = rd_word;
          end
        end
      end else begin
        want_i = instr_rd_en && !m_ivalid;
        want_d = (data_rd_en || data_wr_en) && !m_dvalid;
        if (want_i || want_d) begin
          pick_d      = want_d && (!want_i || !m_last_data);
          m_last_data = pick_d;
          cur.active  = 1'b1;
          cur.is_data = pick_d;
          cur.age     = 0;
          if (pick_d) begin
            cur.addr  = data_addr;
            cur.we    = data_wr_en;
            cur.wdata = data_write;
          end else begin
            cur.addr  = {12'h000, instr_addr};
            cur.we    = 1'b0;
            cur.wdata = '0;
          end
        end
      end
      m_ivalid = n_iv;
      m_dvalid = n_dv;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_valid(input bit is_data, input bit stall_expected, input string name);
    int n = 0;
    while (!(is_data ? data_valid : instr_valid) && n < 40) begin
      if (stall_expected) check({name, "_stall"}, core_stall, 1);
      tick();
      n++;
    end
    check({name, "_valid_seen"}, is_data ? data_valid : instr_valid, 1);
  endtask

  initial begin
    int count;

    // Reset state
    tick();
    tick();
    check("reset_mem_req", mem_req, 0);
    check("reset_instruction", instruction, 0);
    check("reset_data_read", data_read, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_stall", core_stall, 0);
    rst = 1'b0;
    tick();

    // Fetch only, ack two cycles after mem_req
    ack_delay   = 2;
    rdata_value = 32'h2001_0005;
    instr_addr  = 20'h40000;
    instr_rd_en = 1'b1;
    tick();
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, 32'h0004_0000);
    check("fetch_mem_we", mem_we, 0);
    wait_valid(1'b0, 1'b1, "fetch");
    check("fetch_instruction", instruction, 32'h2001_0005);
    instr_rd_en = 1'b0;
    tick();
    check("fetch_single_pulse", instr_valid, 0);
    check("fetch_held", instruction, 32'h2001_0005);

    // Fetch and load together, last grant was fetch: data goes first
    ack_delay   = 1;
    rdata_value = 32'h1111_2222;
    instr_addr  = 20'h00123;
    instr_rd_en = 1'b1;
    data_addr   = 32'h0000_0200;
    data_rd_en  = 1'b1;
    tick();
    check("rr_data_first_addr", mem_addr, 32'h0000_0200);
    check("rr_data_first_we", mem_we, 0);
    wait_valid(1'b1, 1'b1, "rr_load");
    check("rr_load_data", data_read, 32'h1111_2222);
    data_rd_en  = 1'b0;
    rdata_value = 32'h3333_4444;
    check("rr_stall_fetch_pending", core_stall, 1);
    tick();
    check("rr_fetch_second_addr", mem_addr, 32'h0000_0123);
    wait_valid(1'b0, 1'b1, "rr_fetch");
    check("rr_fetch_word", instruction, 32'h3333_4444);
    instr_rd_en = 1'b0;
    tick();

    // Store, ack in the same cycle as mem_req
    ack_delay  = 0;
    data_addr  = 32'h0000_0100;
    data_write = 32'hCAFE_BABE;
    data_wr_en = 1'b1;
    tick();
    check("store_mem_we", mem_we, 1);
    check("store_mem_wdata", mem_wdata, 32'hCAFE_BABE);
    check("store_mem_addr", mem_addr, 32'h0000_0100);
    wait_valid(1'b1, 1'b0, "store");
    check("store_data_read_kept", data_read, 32'h1111_2222);
    data_wr_en = 1'b0;
    tick();
    check("store_single_pulse", data_valid, 0);

    // Read and write both high: treated as a write
    data_addr  = 32'h0000_0104;
    data_write = 32'h5A5A_5A5A;
    data_rd_en = 1'b1;
    data_wr_en = 1'b1;
    tick();
    check("rw_is_write", mem_we, 1);
    wait_valid(1'b1, 1'b0, "rw");
    check("rw_data_read_kept", data_read, 32'h1111_2222);
    data_rd_en = 1'b0;
    data_wr_en = 1'b0;
    tick();

    // Timeout on a load: no ack ever
    ack_delay  = 1000;
    data_addr  = 32'h0000_0300;
    data_rd_en = 1'b1;
    tick();
    count = 0;
    while (mem_req && count < 20) begin
      count++;
      tick();
    end
    check("timeout_req_cycles", count, TO);
    check("timeout_valid", data_valid, 1);
    check("timeout_data_zero", data_read, 0);
    check("timeout_err_set", timeout_err, 1);
    data_rd_en = 1'b0;
    tick();
    check("timeout_err_sticky", timeout_err, 1);
    check("timeout_single_pulse", data_valid, 0);

    // Reset in the middle of a data grant
    data_addr  = 32'h0000_0400;
    data_rd_en = 1'b1;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_timeout_err", timeout_err, 0);
    check("midrst_stall", core_stall, 1);
    tick();
    rst         = 1'b0;
    ack_delay   = 2;
    rdata_value = 32'h0BAD_F00D;
    tick();
    check("postrst_regrant", mem_req, 1);
    check("postrst_addr", mem_addr, 32'h0000_0400);
    wait_valid(1'b1, 1'b1, "postrst");
    check("postrst_data", data_read, 32'h0BAD_F00D);
    data_rd_en = 1'b0;
    tick();

    // Randomized traffic with occasional resets
    random_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end
    end
    random_mode = 1'b0;
    instr_rd_en = 1'b0;
    data_rd_en  = 1'b0;
    data_wr_en  = 1'b0;
    ack_delay   = 0;
    for (int i = 0; i < 20; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
